// File: rtl/sum_uart_tx.sv
// 8N1 UART transmitter for adder results: valid/ready input, one-byte holding
// buffer so back-to-back bytes go out with no idle gap between frames.
module sum_uart_tx #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_count
);
    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    buf_q, buf_d;
    logic          buf_full_q, buf_full_d;
    logic [7:0]    count_q, count_d;
    logic          xfer, baud_last, bit_end;

    assign in_ready    = !buf_full_q;
    assign xfer        = in_valid && !buf_full_q;
    assign baud_last   = (baud_q == BAUD_LAST);
    assign bit_end     = (state_q != IDLE) && baud_last;
    assign busy        = (state_q != IDLE);
    assign frame_done  = (state_q == STOP) && baud_last;
    assign frame_count = count_q;

    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        count_d    = count_q;

        if (state_q != IDLE)
            baud_d = baud_last ? '0 : baud_q + BW'(1);

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    shift_d = in_data;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = STOP;
                end
            end
            STOP: begin
                if (baud_last) begin
                    count_d = count_q + 8'd1;
                    if (buf_full_q) begin
                        shift_d    = buf_q;
                        buf_full_d = 1'b0;
                        state_d    = START;
                    end else if (xfer) begin
                        shift_d = in_data;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte arriving mid-frame parks in the buffer, except at the very end
        // of a stop bit where it goes straight into the shifter instead.
        if (xfer && (state_q != IDLE) && !(state_q == STOP && bit_end)) begin
            buf_d      = in_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            buf_q      <= 8'd0;
            buf_full_q <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            count_q    <= count_d;
        end
    end
endmodule

// File: tb/tb_sum_uart_tx.sv
// Bench for sum_uart_tx: fixed frame table, back-to-back/back-pressure and
// mid-frame reset sequences, randomized stream decoded by a UART receiver model.
module tb_sum_uart_tx;
    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, tx, busy, frame_done;
    logic [7:0] in_data, frame_count;
    logic       rst2, in_valid2, in_ready2, tx2, busy2, fd2;
    logic [7:0] in_data2, fc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sum_uart_tx #(.CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx(tx), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count));

    sum_uart_tx #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst2), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .tx(tx2), .busy(busy2), .frame_done(fd2),
        .frame_count(fc2));

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic [7:0] count;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_single(input logic [7:0] d, input logic [9:0] frame,
                               input logic [7:0] cnt, input string tag);
        logic [39:0] got, exp;
        int fdn, fdc;
        logic busy_ok;
        tick();
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        chk({tag, "_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_data  = ~d;
        fdn = 0; fdc = 0; busy_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            got[c-1] = tx;
            exp[c-1] = frame[(c-1)/CD];
            if (frame_done) begin fdn++; fdc = c; end
            if (!busy) busy_ok = 1'b0;
            if (c == 17) in_data = $urandom;
        end
        @(negedge clk);
        chk({tag, "_wave"}, got, exp);
        chk({tag, "_fd_cnt"}, fdn, 1);
        chk({tag, "_fd_cyc"}, fdc, 40);
        chk({tag, "_busy_held"}, busy_ok, 1);
        chk({tag, "_busy_fall"}, busy, 0);
        chk({tag, "_idle_tx"}, tx, 1);
        chk({tag, "_count"}, frame_count, cnt);
    endtask

    task automatic back_to_back();
        logic [7:0] bytes [3];
        int acc [3];
        logic tx_cap [125], rdy_cap [125], fd_cap [125], busy_cap [125];
        logic [39:0] got, exp;
        logic [9:0] fr;
        int fdn;
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
        tick();
        in_valid = 1'b1;
        fork
            begin
                int dk;
                dk = 0;
                for (int i = 0; i < 3; i++) begin
                    in_data = bytes[i];
                    acc[i] = -1;
                    while (acc[i] < 0 && dk < 300) begin
                        @(negedge clk);
                        if (in_ready) acc[i] = dk;
                        dk++;
                    end
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0;
            end
            begin
                for (int ck = 0; ck < 125; ck++) begin
                    @(negedge clk);
                    tx_cap[ck] = tx; rdy_cap[ck] = in_ready;
                    fd_cap[ck] = frame_done; busy_cap[ck] = busy;
                end
            end
        join
        chk("b2b_acc0", acc[0], 0);
        chk("b2b_acc1", acc[1], 1);
        chk("bp_acc2_after_fd", acc[2], 41);
        chk("b2b_ready_low", rdy_cap[2], 0);
        chk("bp_ready_at_fd", rdy_cap[40], 0);
        chk("bp_ready_rise", rdy_cap[41], 1);
        for (int j = 0; j < 3; j++) begin
            fr = {1'b1, bytes[j], 1'b0};
            for (int i = 0; i < 40; i++) begin
                got[i] = tx_cap[1 + j*40 + i];
                exp[i] = fr[i/CD];
            end
            chk($sformatf("b2b_wave%0d", j), got, exp);
        end
        fdn = 0;
        for (int ck = 0; ck < 125; ck++) if (fd_cap[ck]) fdn++;
        chk("b2b_fd_cnt", fdn, 3);
        chk("b2b_fd_pos", {fd_cap[40], fd_cap[80], fd_cap[120]}, 3'b111);
        chk("b2b_busy_120", busy_cap[120], 1);
        chk("b2b_busy_121", busy_cap[121], 0);
        chk("b2b_count", frame_count, 7);
    endtask

    task automatic mid_reset();
        logic stray;
        tick();
        in_valid = 1'b1;
        in_data  = 8'h11;
        tick();
        in_data  = 8'h22;
        @(negedge clk);
        chk("mr_ready_k1", in_ready, 1);
        tick();
        in_valid = 1'b0;
        repeat (16) tick();
        @(negedge clk);
        chk("mr_pre_busy", busy, 1);
        chk("mr_pre_buf_full", in_ready, 0);
        chk("mr_pre_tx_bit3", tx, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mr_tx", tx, 1);
        chk("mr_busy", busy, 0);
        chk("mr_ready", in_ready, 1);
        chk("mr_count", frame_count, 0);
        stray = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (frame_done || !tx || busy) stray = 1'b1;
        end
        chk("mr_no_activity", stray, 0);
        send_single(8'h3C, 10'b1_0011_1100_0, 8'd1, "mr_3c");
    endtask

    task automatic random_stream(input int n);
        logic [7:0] exp_q [$];
        int rx_n;
        tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        rx_n = 0;
        fork
            begin
                int gap;
                logic ok;
                for (int i = 0; i < n; i++) begin
                    gap = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 60) : $urandom_range(0, 3);
                    in_valid = 1'b0;
                    repeat (gap) begin in_data = $urandom; tick(); end
                    in_data  = $urandom;
                    in_valid = 1'b1;
                    ok = 1'b0;
                    for (int w = 0; w < 400 && !ok; w++) begin
                        @(negedge clk);
                        if (in_ready) begin exp_q.push_back(in_data); ok = 1'b1; end
                        tick();
                    end
                    if (!ok) begin chk("rnd_drv_timeout", 0, 1); break; end
                end
                in_valid = 1'b0;
            end
            begin
                logic found;
                logic [7:0] d, e;
                logic st, sp;
                for (int f = 0; f < n; f++) begin
                    found = 1'b0;
                    for (int w = 0; w < 500; w++) begin
                        @(negedge clk);
                        if (tx == 1'b0) begin found = 1'b1; break; end
                    end
                    if (!found) begin chk("rnd_rx_timeout", 0, 1); break; end
                    repeat (CD/2) @(negedge clk);
                    st = tx;
                    for (int b = 0; b < 8; b++) begin
                        repeat (CD) @(negedge clk);
                        d[b] = tx;
                    end
                    repeat (CD) @(negedge clk);
                    sp = tx;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    chk($sformatf("rnd_frame%0d", f), {sp, d, st}, {1'b1, e, 1'b0});
                    rx_n++;
                end
            end
        join
        for (int w = 0; w < 100 && busy; w++) @(negedge clk);
        @(negedge clk);
        chk("rnd_rx_total", rx_n, n);
        chk("rnd_idle", busy, 0);
        chk("wrap_count", frame_count, n % 256);
    endtask

    task automatic div2_frame();
        logic [19:0] got, exp;
        int blen, fdc;
        tick();
        in_valid2 = 1'b1;
        in_data2  = 8'hFF;
        @(negedge clk);
        chk("d2_ready", in_ready2, 1);
        tick();
        in_valid2 = 1'b0;
        blen = 0; fdc = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c <= 20) begin
                got[c-1] = tx2;
                exp[c-1] = (c > 2);
            end
            if (busy2) blen++;
            if (fd2) fdc = c;
        end
        chk("d2_wave", got, exp);
        chk("d2_busy_len", blen, 20);
        chk("d2_fd_cyc", fdc, 20);
        chk("d2_count", fc2, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [4];
        tbl[0] = '{8'hA5, 10'b1_1010_0101_0, 8'd1};
        tbl[1] = '{8'h00, 10'b1_0000_0000_0, 8'd2};
        tbl[2] = '{8'hFF, 10'b1_1111_1111_0, 8'd3};
        tbl[3] = '{8'h81, 10'b1_1000_0001_0, 8'd4};

        rst = 1'b1; rst2 = 1'b1;
        in_valid = 1'b0; in_valid2 = 1'b0;
        in_data = 8'h00; in_data2 = 8'h00;
        repeat (3) tick();
        rst = 1'b0; rst2 = 1'b0;
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_fd", frame_done, 0);
        chk("rst_count", frame_count, 0);

        for (int i = 0; i < 4; i++)
            send_single(tbl[i].data, tbl[i].frame, tbl[i].count, $sformatf("tbl%0d", i));

        back_to_back();
        mid_reset();
        random_stream(256);
        div2_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
